// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: holds the architectural PC, computes next PC and runs the imem req/ack handshake.
// Optional macro FETCH_MISALIGN_TRAP_EN redirects misaligned branch targets to TRAP_VECTOR.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 'h100,
  parameter int unsigned     CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fetch_en_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_imm_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic             imem_ack_i,
  output logic             instr_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_next_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic             misalign_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_d;
  logic              imem_req_q;
  logic              instr_valid_q;
  logic [CNT_W-1:0]  fetch_count_q;

  logic [XLEN-1:0]   seq_target;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   pc_target;
  logic              pc_update;

  assign seq_target = pc_q + XLEN'(INSTR_BYTES);
  assign br_target  = pc_q + (branch_imm_i << 1);
  assign pc_target  = branch_taken_i ? br_target : seq_target;

  // PC advances on an unstalled ack in REQ, or on the first unstalled cycle of HOLD.
  assign pc_update = !stall_i && ((state_q == REQ && imem_ack_i) || state_q == HOLD);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic br_misaligned;
  logic misalign_q;

  assign br_misaligned = branch_taken_i && (br_target[1:0] != 2'b00);
  assign pc_d          = br_misaligned ? TRAP_VECTOR : pc_target;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      misalign_q <= 1'b0;
    end else if (pc_update && br_misaligned) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign pc_d       = pc_target;
  assign misalign_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; reset is tested first so it overrides all other inputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      instr_valid_q <= 1'b0;
      if (pc_update) begin
        pc_q <= pc_d;
      end
      case (state_q)
        IDLE: begin
          if (fetch_en_i) begin
            state_q    <= REQ;
            imem_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack_i) begin
            instr_valid_q <= 1'b1;
            fetch_count_q <= fetch_count_q + CNT_W'(1);
            if (stall_i) begin
              state_q    <= HOLD;
              imem_req_q <= 1'b0;
            end else if (fetch_en_i) begin
              state_q    <= REQ;
              imem_req_q <= 1'b1;
            end else begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_q    <= fetch_en_i ? REQ : IDLE;
            imem_req_q <= fetch_en_i;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign pc_next_o     = pc_d;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: vector table plus handshake-address scoreboard,
// and a second instance with a wrapping RESET_PC for reset/overflow corner cases.
module tb_pc_fetch_sequencer;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit              MIS_ON   = 1'b1;
  localparam logic [XLEN-1:0] MIS_DEST = 64'h100;
`else
  localparam bit              MIS_ON   = 1'b0;
  localparam logic [XLEN-1:0] MIS_DEST = 64'h12;
`endif
  localparam logic [XLEN-1:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic             clk = 1'b0;
  logic             reset, fetch_en, stall, branch_taken, imem_ack;
  logic [XLEN-1:0]  branch_imm;
  logic             imem_req, instr_valid, misalign;
  logic [XLEN-1:0]  imem_addr, pc_out, pc_next;
  logic [CNT_W-1:0] fetch_count;

  logic             w_reset, w_fetch_en, w_ack;
  logic             w_req, w_valid, w_mis;
  logic [XLEN-1:0]  w_addr, w_pc, w_pc_next;
  logic [CNT_W-1:0] w_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [XLEN-1:0] sb_q[$];

  always #5 clk = ~clk;

  pc_fetch_sequencer u_dut (
    .clk_i(clk), .reset_i(reset), .fetch_en_i(fetch_en), .stall_i(stall),
    .branch_taken_i(branch_taken), .branch_imm_i(branch_imm),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
    .instr_valid_o(instr_valid), .pc_o(pc_out), .pc_next_o(pc_next),
    .fetch_count_o(fetch_count), .misalign_o(misalign)
  );

  pc_fetch_sequencer #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk_i(clk), .reset_i(w_reset), .fetch_en_i(w_fetch_en), .stall_i(1'b0),
    .branch_taken_i(1'b0), .branch_imm_i(64'h0),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack),
    .instr_valid_o(w_valid), .pc_o(w_pc), .pc_next_o(w_pc_next),
    .fetch_count_o(w_count), .misalign_o(w_mis)
  );

  typedef struct {
    string           name;
    bit              rst, fen, stl, ack, br;
    logic [XLEN-1:0] imm;
    bit              req;
    logic [XLEN-1:0] addr;
    bit              valid;
    int              cnt;
    bit              mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(string n, bit rst, bit fen, bit stl, bit ack, bit br,
                             logic [XLEN-1:0] imm, bit req, logic [XLEN-1:0] addr,
                             bit valid, int cnt, bit mis);
    vec_t r;
    r.name = n; r.rst = rst; r.fen = fen; r.stl = stl; r.ack = ack; r.br = br;
    r.imm = imm; r.req = req; r.addr = addr; r.valid = valid; r.cnt = cnt; r.mis = mis;
    return r;
  endfunction

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Scoreboard: every handshake seen on the bus must match the next queued address.
  always @(negedge clk) begin
    if (!reset && imem_req && imem_ack) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL hs_unexpected: handshake at 0x%0h with no expected entry", imem_addr);
      end else begin
        check("hs_addr", imem_addr, sb_q.pop_front());
      end
    end
  end

  task automatic wcycle(bit rst, bit fen, bit ack);
    w_reset = rst; w_fetch_en = fen; w_ack = ack;
    @(posedge clk); #1;
  endtask

  initial begin
    logic            prev_req;
    logic [XLEN-1:0] prev_addr;
    logic [XLEN-1:0] neg16, neg2;
    neg16 = -64'sd16;
    neg2  = -64'sd2;

    reset = 1'b1; fetch_en = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_imm = '0; imem_ack = 1'b0;
    w_reset = 1'b1; w_fetch_en = 1'b0; w_ack = 1'b0;

    //              name          rst fen stl ack br imm      req addr          vld cnt mis
    vecs.push_back(v("reset0",     1, 0, 0, 0, 0, 0,        0, 64'h0,         0, 0,  0));
    vecs.push_back(v("reset1",     1, 0, 0, 0, 0, 0,        0, 64'h0,         0, 0,  0));
    vecs.push_back(v("idle_ack",   0, 0, 0, 1, 0, 0,        0, 64'h0,         0, 0,  0));
    vecs.push_back(v("start",      0, 1, 0, 1, 0, 0,        1, 64'h0,         0, 0,  0));
    vecs.push_back(v("fetch0",     0, 1, 0, 1, 0, 0,        1, 64'h4,         1, 1,  0));
    vecs.push_back(v("fetch4",     0, 1, 0, 1, 0, 0,        1, 64'h8,         1, 2,  0));
    vecs.push_back(v("fetch8",     0, 1, 0, 1, 0, 0,        1, 64'hC,         1, 3,  0));
    vecs.push_back(v("fetchC",     0, 1, 0, 1, 0, 0,        1, 64'h10,        1, 4,  0));
    vecs.push_back(v("wait1",      0, 1, 0, 0, 0, 0,        1, 64'h10,        0, 4,  0));
    vecs.push_back(v("wait2",      0, 1, 0, 0, 0, 0,        1, 64'h10,        0, 4,  0));
    vecs.push_back(v("wait3",      0, 1, 0, 0, 0, 0,        1, 64'h10,        0, 4,  0));
    vecs.push_back(v("br_fwd",     0, 1, 0, 1, 1, 64'h8,    1, 64'h20,        1, 5,  0));
    vecs.push_back(v("br_back",    0, 1, 0, 1, 1, neg16,    1, 64'h0,         1, 6,  0));
    vecs.push_back(v("seq",        0, 1, 0, 1, 0, 0,        1, 64'h4,         1, 7,  0));
    vecs.push_back(v("stall_ack",  0, 1, 1, 1, 0, 0,        0, 64'h4,         1, 8,  0));
    vecs.push_back(v("stall2",     0, 1, 1, 1, 0, 0,        0, 64'h4,         0, 8,  0));
    vecs.push_back(v("stall3",     0, 1, 1, 1, 0, 0,        0, 64'h4,         0, 8,  0));
    vecs.push_back(v("stall4",     0, 1, 1, 1, 0, 0,        0, 64'h4,         0, 8,  0));
    vecs.push_back(v("stall5",     0, 1, 1, 1, 0, 0,        0, 64'h4,         0, 8,  0));
    vecs.push_back(v("release",    0, 1, 0, 0, 0, 0,        1, 64'h8,         0, 8,  0));
    vecs.push_back(v("fen_drop",   0, 0, 0, 0, 0, 0,        1, 64'h8,         0, 8,  0));
    vecs.push_back(v("drop_ack",   0, 0, 0, 1, 0, 0,        0, 64'hC,         1, 9,  0));
    vecs.push_back(v("idle2",      0, 0, 0, 1, 0, 0,        0, 64'hC,         0, 9,  0));
    vecs.push_back(v("req_c",      0, 1, 0, 0, 0, 0,        1, 64'hC,         0, 9,  0));
    vecs.push_back(v("hold_c",     0, 0, 1, 1, 0, 0,        0, 64'hC,         1, 10, 0));
    vecs.push_back(v("hold_br",    0, 0, 0, 0, 1, 64'h2,    0, 64'h10,        0, 10, 0));
    vecs.push_back(v("req_10",     0, 1, 0, 0, 0, 0,        1, 64'h10,        0, 10, 0));
    vecs.push_back(v("mis_br",     0, 1, 0, 1, 1, 64'h1,    1, MIS_DEST,      1, 11, MIS_ON));
    vecs.push_back(v("mis_seq",    0, 0, 0, 1, 0, 0,        0, MIS_DEST + 4,  1, 12, MIS_ON));
    vecs.push_back(v("req_again",  0, 1, 0, 0, 0, 0,        1, MIS_DEST + 4,  0, 12, MIS_ON));
    vecs.push_back(v("rst_mid",    1, 0, 0, 0, 0, 0,        0, 64'h0,         0, 0,  0));
    vecs.push_back(v("late_ack",   0, 0, 0, 1, 0, 0,        0, 64'h0,         0, 0,  0));

    prev_req  = 1'b0;
    prev_addr = '0;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; fetch_en = vecs[i].fen; stall = vecs[i].stl;
      imem_ack = vecs[i].ack; branch_taken = vecs[i].br; branch_imm = vecs[i].imm;
      if (vecs[i].ack && !vecs[i].rst && prev_req) sb_q.push_back(prev_addr);
      // NOTE: outputs are sampled 1 time unit after the edge, never on it.
      @(posedge clk); #1;
      check({vecs[i].name, ".req"},   64'(imem_req),    64'(vecs[i].req));
      check({vecs[i].name, ".addr"},  imem_addr,        vecs[i].addr);
      check({vecs[i].name, ".pc"},    pc_out,           vecs[i].addr);
      check({vecs[i].name, ".valid"}, 64'(instr_valid), 64'(vecs[i].valid));
      check({vecs[i].name, ".count"}, 64'(fetch_count), 64'(vecs[i].cnt));
      check({vecs[i].name, ".mis"},   64'(misalign),    64'(vecs[i].mis));
      prev_req  = vecs[i].req;
      prev_addr = vecs[i].addr;
    end

    // pc_next is combinational in IDLE: 0 + (-2 << 1) wraps to ...FFFC.
    fetch_en = 1'b0; imem_ack = 1'b0; branch_taken = 1'b1; branch_imm = neg2;
    #1;
    check("pc_next_idle_br", pc_next, 64'hFFFF_FFFF_FFFF_FFFC);
    branch_taken = 1'b0;
    #1;
    check("pc_next_idle_seq", pc_next, 64'h4);
    check("sb_drain", 64'(sb_q.size()), 64'h0);

    // Wrapping RESET_PC instance: overflow on +4, then reset mid-REQ with a late ack.
    wcycle(1, 0, 0);
    wcycle(1, 0, 0);
    check("wrap.reset_pc", w_pc, WRAP_PC);
    check("wrap.reset_req", 64'(w_req), 64'h0);
    wcycle(0, 1, 0);
    check("wrap.req_addr", w_addr, WRAP_PC);
    check("wrap.req", 64'(w_req), 64'h1);
    wcycle(0, 0, 1);
    check("wrap.overflow_pc", w_pc, 64'h0);
    check("wrap.count1", 64'(w_count), 64'h1);
    wcycle(1, 0, 0);
    wcycle(0, 1, 0);
    check("wrap.req2", 64'(w_req), 64'h1);
    wcycle(1, 0, 0);
    check("wrap.rst_mid_req", 64'(w_req), 64'h0);
    check("wrap.rst_mid_pc", w_pc, WRAP_PC);
    wcycle(0, 0, 1);
    check("wrap.late_ack_req", 64'(w_req), 64'h0);
    check("wrap.late_ack_valid", 64'(w_valid), 64'h0);
    check("wrap.late_ack_count", 64'(w_count), 64'h0);
    check("wrap.late_ack_pc", w_pc, WRAP_PC);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
